cpu_debug_ctrl: RTL and testbench

Run/step/breakpoint controller for the board-test single-cycle MIPS CPU. Consumes command bytes from the UART RX FIFO and rising edges of the debounced step button. Sequences the CPU through a one-cycle clock-enable pulse and a CPU reset. After each step or run stop, it requests a register dump from the UART dump controller.

---
 rtl/cpu_debug_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_cpu_debug_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl: run/step/breakpoint sequencer for the board-test MIPS CPU.
// Commands arrive as bytes from the UART RX FIFO (show-ahead) or as rising
// edges of the debounced step button. The controller gates the CPU with a
// one-cycle clock-enable (cpu_step), holds the CPU in reset on request, and
// asks the UART dump controller for a register dump after every step or run.
`timescale 1ns/1ps

module cpu_debug_ctrl #(
    parameter int PC_W       = 32,
    parameter int CNT_W      = 24,
    parameter int RST_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [7:0]      r_data,
    output logic            rd,
    input  logic            step_btn,
    input  logic [PC_W-1:0] cpu_pc,
    input  logic            cpu_done,
    output logic            cpu_step,
    output logic            cpu_rst_n,
    output logic            dump_req,
    input  logic            dump_busy,
    output logic            halted,
    output logic [15:0]     step_cnt
);

    // Command bytes understood by the controller.
    localparam logic [7:0] CMD_STEP  = 8'h73; // 's'
    localparam logic [7:0] CMD_RUN   = 8'h72; // 'r'
    localparam logic [7:0] CMD_RESET = 8'h78; // 'x'
    localparam logic [7:0] CMD_BP    = 8'h62; // 'b'
    localparam logic [7:0] CMD_CLEAR = 8'h63; // 'c'
    localparam logic [7:0] CMD_HALT  = 8'h68; // 'h'

    // Reset-cycle counter only needs to reach RST_CYCLES-1.
    localparam int              RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RST,
        S_IDLE,
        S_STEP,
        S_RUN,
        S_BP_LOAD,
        S_DUMP_REQ,
        S_DUMP_WAIT
    } state_t;

    state_t            state;
    state_t            state_d;

    logic [RST_W-1:0]  rst_cnt;     // cycles spent in S_RST so far
    logic [CNT_W-1:0]  run_cnt;     // steps issued in the current run
    logic              run_first;   // first cycle of a run: breakpoint is masked
    logic [2:0]        nib_cnt;     // hex digits accepted in S_BP_LOAD
    logic [PC_W-1:0]   shadow;      // breakpoint being assembled
    logic [PC_W-1:0]   shadow_next;
    logic [PC_W-1:0]   bp;
    logic              bp_en;
    logic              btn_q;

    logic              btn_edge;
    logic [4:0]        hex;         // {valid, value} of the FIFO head byte
    logic              bp_hit;
    logic              run_stop;
    logic              enter_rst;
    logic              enter_run;
    logic              bp_digit;    // valid hex digit popped in S_BP_LOAD
    logic              bp_commit;   // final digit of a breakpoint popped
    logic              bp_clear;

    // ASCII hex digit decode; bit 4 flags a valid digit.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] v;
        v = 5'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            v = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            v = {1'b1, c[3:0] + 4'd9};
        end
        return v;
    endfunction

    assign btn_edge    = step_btn & ~btn_q;
    assign hex         = hex_decode(r_data);
    assign shadow_next = (shadow << 4) | PC_W'(hex[3:0]);
    assign bp_hit      = bp_en && (cpu_pc == bp) && !run_first;

    // Registered-state decodes.
    assign halted    = (state == S_IDLE);
    assign cpu_rst_n = (state != S_RST);
    assign dump_req  = (state == S_DUMP_REQ);

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous, so it lives inside the clocked
        // branch and is only seen on a rising clk edge.
        if (!reset) begin
            state <= S_RST;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state <= state_d;
        end
    end

    // Next-state decode plus the two combinational outputs rd and cpu_step.
    always_comb begin
        // NOTE: every output gets a default first; a path that skips an
        // assignment would otherwise infer a latch.
        state_d   = state;
        rd        = 1'b0;
        cpu_step  = 1'b0;
        run_stop  = 1'b0;
        bp_digit  = 1'b0;
        bp_commit = 1'b0;
        bp_clear  = 1'b0;

        case (state)
            S_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                // UART wins over the button; an edge in the same cycle is lost.
                if (!rx_empty) begin
                    rd = 1'b1;
                    case (r_data)
                        CMD_STEP:  state_d = cpu_done ? S_DUMP_REQ : S_STEP;
                        CMD_RUN:   state_d = cpu_done ? S_DUMP_REQ : S_RUN;
                        CMD_RESET: state_d = S_RST;
                        CMD_BP:    state_d = S_BP_LOAD;
                        CMD_CLEAR: bp_clear = 1'b1;
                        default:   state_d = S_IDLE;
                    endcase
                end else if (btn_edge) begin
                    state_d = cpu_done ? S_DUMP_REQ : S_STEP;
                end
            end

            S_STEP: begin
                cpu_step = 1'b1;
                state_d  = S_DUMP_REQ;
            end

            S_RUN: begin
                // Every byte is drained during a run; only 'h' has an effect.
                rd       = !rx_empty;
                run_stop = cpu_done
                         || bp_hit
                         || (!rx_empty && (r_data == CMD_HALT))
                         || (run_cnt == {CNT_W{1'b1}});
                if (run_stop) begin
                    state_d = S_DUMP_REQ;
                end else begin
                    cpu_step = 1'b1;
                end
            end

            S_BP_LOAD: begin
                if (!rx_empty) begin
                    rd = 1'b1;
                    if (!hex[4]) begin
                        state_d = S_IDLE;
                    end else begin
                        bp_digit = 1'b1;
                        if (nib_cnt == 3'd7) begin
                            bp_commit = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                end
            end

            S_DUMP_REQ: begin
                if (dump_busy) begin
                    state_d = S_DUMP_WAIT;
                end
            end

            S_DUMP_WAIT: begin
                if (!dump_busy) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_RST;
        endcase
    end

    assign enter_rst = (state_d == S_RST) && (state != S_RST);
    assign enter_run = (state_d == S_RUN) && (state != S_RUN);

    // Reset-hold counter, run counter and step counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rst_cnt   <= '0;
            run_cnt   <= '0;
            run_first <= 1'b0;
            step_cnt  <= '0;
        end else begin
            if (enter_rst) begin
                rst_cnt <= '0;
            end else if (state == S_RST) begin
                rst_cnt <= rst_cnt + RST_W'(1);
            end

            if (enter_run) begin
                run_cnt   <= '0;
                run_first <= 1'b1;
            end else if (state == S_RUN) begin
                run_first <= 1'b0;
                if (cpu_step) begin
                    run_cnt <= run_cnt + CNT_W'(1);
                end
            end

            // A CPU reset restarts the count; otherwise count every issued step.
            if (enter_rst) begin
                step_cnt <= '0;
            end else if (cpu_step) begin
                step_cnt <= step_cnt + 16'd1;
            end
        end
    end

    // Breakpoint shadow/commit path and button edge register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            nib_cnt <= '0;
            shadow  <= '0;
            bp      <= '0;
            bp_en   <= 1'b0;
            btn_q   <= step_btn;
        end else begin
            btn_q <= step_btn;

            if (state_d == S_BP_LOAD && state != S_BP_LOAD) begin
                nib_cnt <= '0;
            end else if (bp_digit) begin
                nib_cnt <= nib_cnt + 3'd1;
                shadow  <= shadow_next;
            end

            if (bp_clear) begin
                bp_en <= 1'b0;
            end else if (bp_commit) begin
                bp    <= shadow_next;
                bp_en <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed testbench for cpu_debug_ctrl. Models the RX FIFO as a queue, the
// CPU as a PC that advances by 4 on each cpu_step, and the dump controller
// as a responder that raises dump_busy for three cycles per request.
`timescale 1ns/1ps

module tb_cpu_debug_ctrl;

    localparam int PC_W       = 32;
    localparam int CNT_W      = 4;
    localparam int RST_CYCLES = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            rx_empty;
    logic [7:0]      r_data;
    logic            rd;
    logic            step_btn;
    logic [PC_W-1:0] cpu_pc;
    logic            cpu_done;
    logic            cpu_step;
    logic            cpu_rst_n;
    logic            dump_req;
    logic            dump_busy;
    logic            halted;
    logic [15:0]     step_cnt;

    int asserts = 0;
    int fails   = 0;

    // Event tallies gathered once per clock by cycle().
    int step_pulses = 0;
    int pops        = 0;
    int rst_low     = 0;
    int dumps       = 0;
    int req_cycles  = 0;
    int busy_left   = 0;

    logic [PC_W-1:0] pc_model = '0;
    logic [7:0]      fifo[$];

    cpu_debug_ctrl #(
        .PC_W       (PC_W),
        .CNT_W      (CNT_W),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd        (rd),
        .step_btn  (step_btn),
        .cpu_pc    (cpu_pc),
        .cpu_done  (cpu_done),
        .cpu_step  (cpu_step),
        .cpu_rst_n (cpu_rst_n),
        .dump_req  (dump_req),
        .dump_busy (dump_busy),
        .halted    (halted),
        .step_cnt  (step_cnt)
    );

    always #5 clk = ~clk;

    function automatic void refresh();
        rx_empty = (fifo.size() == 0);
        r_data   = rx_empty ? 8'h00 : fifo[0];
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) fifo.push_back(s.getc(i));
        refresh();
    endtask

    // One clock: sample DUT outputs at the falling edge, then update the
    // FIFO, CPU and dump-controller models just after the rising edge.
    task automatic cycle();
        logic s_rd, s_step, s_req, s_rstn;
        @(negedge clk);
        s_rd   = rd;
        s_step = cpu_step;
        s_req  = dump_req;
        s_rstn = cpu_rst_n;
        if (s_step) step_pulses++;
        if (s_rd)   pops++;
        if (!s_rstn) rst_low++;
        if (s_req)  req_cycles++;
        @(posedge clk);
        #1;
        if (s_rd && fifo.size() != 0) void'(fifo.pop_front());
        if (!s_rstn)     pc_model = '0;
        else if (s_step) pc_model = pc_model + 32'd4;
        cpu_pc = pc_model;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) dump_busy = 1'b0;
        end else if (s_req && !dump_busy) begin
            dump_busy = 1'b1;
            busy_left = 3;
            dumps++;
        end
        refresh();
    endtask

    // Clock until halted, at least once, at most max cycles.
    task automatic wait_idle(input int max, input string name, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!halted && n < max);
        asserts++;
        if (halted !== 1'b1) begin
            $display("FAIL %s_timeout: halted=%b after %0d cycles, required 1", name, halted, n);
            fails++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0; step_btn = 1'b0; cpu_done = 1'b0; dump_busy = 1'b0; cpu_pc = '0;
        refresh();
        for (int i = 0; i < 3; i++) cycle();
        push_str("A");
        #1;
        asserts++; if (rd !== 1'b0)        begin $display("FAIL rst_rd: got %b required 0", rd); fails++; end
        asserts++; if (cpu_step !== 1'b0)  begin $display("FAIL rst_step: got %b required 0", cpu_step); fails++; end
        asserts++; if (dump_req !== 1'b0)  begin $display("FAIL rst_dump: got %b required 0", dump_req); fails++; end
        asserts++; if (cpu_rst_n !== 1'b0) begin $display("FAIL rst_cpu_rst_n: got %b required 0", cpu_rst_n); fails++; end
        reset = 1'b1;
        for (int i = 0; i < RST_CYCLES; i++) begin
            asserts++;
            if (cpu_rst_n !== 1'b0) begin $display("FAIL rst_hold_%0d: cpu_rst_n=%b required 0", i, cpu_rst_n); fails++; end
            cycle();
        end
        asserts++; if (cpu_rst_n !== 1'b1) begin $display("FAIL rst_release: cpu_rst_n=%b required 1", cpu_rst_n); fails++; end
        asserts++; if (halted !== 1'b1)    begin $display("FAIL rst_halted: got %b required 1", halted); fails++; end
        asserts++; if (step_cnt !== 16'd0) begin $display("FAIL rst_step_cnt: got %0d required 0", step_cnt); fails++; end
        // The unknown byte 'A' queued during reset is popped and ignored.
        wait_idle(5, "rst_junk", n);
        asserts++; if (fifo.size() != 0)   begin $display("FAIL rst_junk_pop: fifo=%0d required 0", fifo.size()); fails++; end
        asserts++; if (n != 1)             begin $display("FAIL rst_junk_idle: %0d cycles required 1", n); fails++; end
    endtask

    task automatic test_step();
        int s0, d0, r0, p0, n;
        s0 = step_pulses; d0 = dumps; r0 = req_cycles; p0 = pops;
        push_str("s");
        wait_idle(30, "step", n);
        asserts++; if (pops - p0 != 1)        begin $display("FAIL step_pop: got %0d required 1", pops - p0); fails++; end
        asserts++; if (step_pulses - s0 != 1) begin $display("FAIL step_pulses: got %0d required 1", step_pulses - s0); fails++; end
        asserts++; if (step_cnt !== 16'd1)    begin $display("FAIL step_cnt: got %0d required 1", step_cnt); fails++; end
        asserts++; if (cpu_pc !== 32'h4)      begin $display("FAIL step_pc: got %h required 4", cpu_pc); fails++; end
        asserts++; if (dumps - d0 != 1)       begin $display("FAIL step_dump: got %0d required 1", dumps - d0); fails++; end
        asserts++; if (req_cycles - r0 != 2)  begin $display("FAIL step_req_len: got %0d required 2", req_cycles - r0); fails++; end
        asserts++; if (n != 7)                begin $display("FAIL step_latency: %0d cycles required 7", n); fails++; end
    endtask

    task automatic test_cpu_reset();
        int l0, n;
        l0 = rst_low;
        push_str("x");
        wait_idle(20, "xrst", n);
        asserts++; if (rst_low - l0 != RST_CYCLES) begin $display("FAIL x_rst_len: got %0d required %0d", rst_low - l0, RST_CYCLES); fails++; end
        asserts++; if (step_cnt !== 16'd0)         begin $display("FAIL x_step_cnt: got %0d required 0", step_cnt); fails++; end
        asserts++; if (cpu_rst_n !== 1'b1)         begin $display("FAIL x_cpu_rst_n: got %b required 1", cpu_rst_n); fails++; end
    endtask

    task automatic test_breakpoint();
        int s0, d0, p0, n;
        p0 = pops;
        push_str("b00000010");
        wait_idle(20, "bp_load", n);
        asserts++; if (pops - p0 != 9) begin $display("FAIL bp_load_pops: got %0d required 9", pops - p0); fails++; end
        s0 = step_pulses; d0 = dumps;
        push_str("r");
        wait_idle(40, "bp_run", n);
        asserts++; if (step_pulses - s0 != 4) begin $display("FAIL bp_steps: got %0d required 4", step_pulses - s0); fails++; end
        asserts++; if (cpu_pc !== 32'h10)     begin $display("FAIL bp_pc: got %h required 10", cpu_pc); fails++; end
        asserts++; if (step_cnt !== 16'd4)    begin $display("FAIL bp_step_cnt: got %0d required 4", step_cnt); fails++; end
        asserts++; if (dumps - d0 != 1)       begin $display("FAIL bp_dump: got %0d required 1", dumps - d0); fails++; end
        // A second run starts on the breakpoint and must move past it.
        s0 = step_pulses;
        push_str("r");
        for (int i = 0; i < 4; i++) cycle();
        push_str("h");
        wait_idle(20, "bp_rerun", n);
        asserts++; if (step_pulses - s0 != 3) begin $display("FAIL bp_rerun_steps: got %0d required 3", step_pulses - s0); fails++; end
        asserts++; if (cpu_pc !== 32'h1C)     begin $display("FAIL bp_rerun_pc: got %h required 1c", cpu_pc); fails++; end
        asserts++; if (step_cnt !== 16'd7)    begin $display("FAIL bp_rerun_cnt: got %0d required 7", step_cnt); fails++; end
    endtask

    task automatic test_halt();
        int s0, d0, n;
        s0 = step_pulses; d0 = dumps;
        push_str("r");
        for (int i = 0; i < 8; i++) cycle();
        push_str("h");
        wait_idle(20, "halt", n);
        asserts++; if (step_pulses - s0 != 7) begin $display("FAIL halt_steps: got %0d required 7", step_pulses - s0); fails++; end
        asserts++; if (step_cnt !== 16'd14)   begin $display("FAIL halt_cnt: got %0d required 14", step_cnt); fails++; end
        asserts++; if (cpu_pc !== 32'h38)     begin $display("FAIL halt_pc: got %h required 38", cpu_pc); fails++; end
        asserts++; if (dumps - d0 != 1)       begin $display("FAIL halt_dump: got %0d required 1", dumps - d0); fails++; end
    endtask

    // After 'c' the old breakpoint at 0x10 is gone, so the run goes to the watchdog.
    task automatic test_watchdog();
        int s0, n;
        push_str("x");
        wait_idle(20, "wd_reset", n);
        push_str("c");
        wait_idle(5, "wd_clear", n);
        s0 = step_pulses;
        push_str("r");
        wait_idle(60, "wd_run", n);
        asserts++; if (step_pulses - s0 != 15) begin $display("FAIL wd_steps: got %0d required 15", step_pulses - s0); fails++; end
        asserts++; if (step_cnt !== 16'd15)    begin $display("FAIL wd_cnt: got %0d required 15", step_cnt); fails++; end
        asserts++; if (cpu_pc !== 32'h3C)      begin $display("FAIL wd_pc: got %h required 3c", cpu_pc); fails++; end
    endtask

    task automatic test_bad_bp();
        int s0, n;
        push_str("b0000006C");
        wait_idle(20, "bad_load", n);
        push_str("b1aG");
        wait_idle(20, "bad_abort", n);
        asserts++; if (n != 4)           begin $display("FAIL bad_abort_len: %0d cycles required 4", n); fails++; end
        asserts++; if (fifo.size() != 0) begin $display("FAIL bad_abort_fifo: %0d bytes required 0", fifo.size()); fails++; end
        s0 = step_pulses;
        push_str("r");
        wait_idle(60, "bad_run", n);
        asserts++; if (step_pulses - s0 != 12) begin $display("FAIL bad_steps: got %0d required 12", step_pulses - s0); fails++; end
        asserts++; if (cpu_pc !== 32'h6C)      begin $display("FAIL bad_pc: got %h required 6c", cpu_pc); fails++; end
        asserts++; if (step_cnt !== 16'd27)    begin $display("FAIL bad_cnt: got %0d required 27", step_cnt); fails++; end
    endtask

    task automatic test_button();
        int s0, n;
        s0 = step_pulses;
        step_btn = 1'b1;
        push_str("s");
        wait_idle(30, "btn_collide", n);
        asserts++; if (step_pulses - s0 != 1) begin $display("FAIL btn_collide: got %0d steps required 1", step_pulses - s0); fails++; end
        step_btn = 1'b0;
        cycle();
        s0 = step_pulses;
        step_btn = 1'b1;
        wait_idle(30, "btn_edge", n);
        asserts++; if (step_pulses - s0 != 1) begin $display("FAIL btn_edge: got %0d steps required 1", step_pulses - s0); fails++; end
        s0 = step_pulses;
        for (int i = 0; i < 5; i++) cycle();
        asserts++; if (step_pulses - s0 != 0) begin $display("FAIL btn_held: got %0d steps required 0", step_pulses - s0); fails++; end
        step_btn = 1'b0;
        asserts++; if (step_cnt !== 16'd29)   begin $display("FAIL btn_cnt: got %0d required 29", step_cnt); fails++; end
        asserts++; if (cpu_pc !== 32'h74)     begin $display("FAIL btn_pc: got %h required 74", cpu_pc); fails++; end
    endtask

    task automatic test_done();
        int s0, d0, n;
        cpu_done = 1'b1;
        s0 = step_pulses; d0 = dumps;
        push_str("s");
        wait_idle(30, "done_s", n);
        push_str("r");
        wait_idle(30, "done_r", n);
        asserts++; if (step_pulses - s0 != 0) begin $display("FAIL done_steps: got %0d required 0", step_pulses - s0); fails++; end
        asserts++; if (dumps - d0 != 2)       begin $display("FAIL done_dumps: got %0d required 2", dumps - d0); fails++; end
        asserts++; if (step_cnt !== 16'd29)   begin $display("FAIL done_cnt: got %0d required 29", step_cnt); fails++; end
        cpu_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_cpu_reset();
        test_breakpoint();
        test_halt();
        test_watchdog();
        test_bad_bp();
        test_button();
        test_done();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
